// File: rtl/ysyx_25060170_ifetch_mem_pkg.sv
// Shared definitions for the instruction-fetch memory stage: FSM encoding,
// AXI read-response codes and the response-to-fault helper.
package ysyx_25060170_ifetch_mem_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      REQ    = 2'b01,
      WAIT_R = 2'b10,
      HOLD   = 2'b11
   } fetch_state_e;

   localparam logic [1:0] RESP_OKAY = 2'b00;

   function automatic logic resp_fault(input logic [1:0] resp);
      return (resp != RESP_OKAY);
   endfunction

endpackage

// File: rtl/ysyx_25060170_inst_hold_reg.sv
// Holding register for the instruction presented to decode: word, its PC and
// the access-fault flag, loaded once per accepted read response.
module ysyx_25060170_inst_hold_reg
   import ysyx_25060170_ifetch_mem_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [DATA_W-1:0] next_inst,
   input  logic [ADDR_W-1:0] next_pc,
   input  logic [1:0]        next_resp,
   output logic [DATA_W-1:0] inst,
   output logic [ADDR_W-1:0] pc,
   output logic              fault
);

   logic [DATA_W-1:0] inst_r;
   logic [ADDR_W-1:0] pc_r;
   logic              fault_r;

   // Capture the response on load; otherwise keep the held instruction stable.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         inst_r  <= '0;
         pc_r    <= '0;
         fault_r <= 1'b0;
      end else if (load) begin
         inst_r  <= next_inst;
         pc_r    <= next_pc;
         fault_r <= resp_fault(next_resp);
      end else begin
         inst_r  <= inst_r;
         pc_r    <= pc_r;
         fault_r <= fault_r;
      end
   end

   assign inst  = inst_r;
   assign pc    = pc_r;
   assign fault = fault_r;

endmodule

// File: rtl/ysyx_25060170_ifetch_mem.sv
// Instruction-fetch memory stage: issues one AR/R read per PC, holds the
// returned word for decode and tells the IFU when the PC may be written.
module ysyx_25060170_ifetch_mem
   import ysyx_25060170_ifetch_mem_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] pc_i,
   input  logic              flush_i,
   output logic              pc_advance_o,
   output logic [ADDR_W-1:0] araddr_o,
   output logic              arvalid_o,
   input  logic              arready_i,
   input  logic [DATA_W-1:0] rdata_i,
   input  logic [1:0]        rresp_i,
   input  logic              rvalid_i,
   output logic              rready_o,
   output logic [DATA_W-1:0] inst_o,
   output logic [ADDR_W-1:0] inst_pc_o,
   output logic              inst_fault_o,
   output logic              inst_valid_o,
   input  logic              inst_ready_i
);

   fetch_state_e      state_r;
   fetch_state_e      state_s;
   logic              discard_r;
   logic              discard_s;
   logic [ADDR_W-1:0] araddr_r;
   logic [ADDR_W-1:0] araddr_s;
   logic              load_s;

   // FSM state, pending-discard flag and the outstanding read address.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r   <= IDLE;
         discard_r <= 1'b0;
         araddr_r  <= '0;
      end else begin
         state_r   <= state_s;
         discard_r <= discard_s;
         araddr_r  <= araddr_s;
      end
   end

   // Next-state logic; a redirect while a read is outstanding poisons its data.
   always_comb begin
      state_s   = state_r;
      discard_s = discard_r;
      araddr_s  = araddr_r;
      load_s    = 1'b0;
      case (state_r)
         IDLE: begin
            if (!flush_i) begin
               araddr_s = pc_i;
               state_s  = REQ;
            end else begin
               state_s  = IDLE;
            end
         end
         REQ: begin
            if (flush_i) begin
               discard_s = 1'b1;
            end else begin
               discard_s = discard_r;
            end
            if (arready_i) begin
               state_s = WAIT_R;
            end else begin
               state_s = REQ;
            end
         end
         WAIT_R: begin
            if (rvalid_i) begin
               discard_s = 1'b0;
               if (discard_r || flush_i) begin
                  state_s = IDLE;
               end else begin
                  load_s  = 1'b1;
                  state_s = HOLD;
               end
            end else if (flush_i) begin
               discard_s = 1'b1;
            end else begin
               state_s = WAIT_R;
            end
         end
         HOLD: begin
            if (inst_ready_i || flush_i) begin
               state_s = IDLE;
            end else begin
               state_s = HOLD;
            end
         end
         default: begin
            state_s   = IDLE;
            discard_s = 1'b0;
         end
      endcase
   end

   ysyx_25060170_inst_hold_reg #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_hold (
      .clk       (clk),
      .rst       (rst),
      .load      (load_s),
      .next_inst (rdata_i),
      .next_pc   (araddr_r),
      .next_resp (rresp_i),
      .inst      (inst_o),
      .pc        (inst_pc_o),
      .fault     (inst_fault_o)
   );

   assign araddr_o     = araddr_r;
   assign arvalid_o    = (state_r == REQ);
   assign rready_o     = (state_r == WAIT_R);
   assign inst_valid_o = (state_r == HOLD);
   // Gated by rst so the IFU sees no PC write while the stage is held in reset.
   assign pc_advance_o = !rst && (((state_r == HOLD) && inst_ready_i) || flush_i);

endmodule

// File: tb/tb_ysyx_25060170_ifetch_mem.sv
// Directed scenarios followed by a randomized run against a transaction-level
// model of the fetch stage (memory, IFU PC register and decode handshake).
module tb_ysyx_25060170_ifetch_mem;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pc_i;
   logic        flush;
   logic        pc_advance;
   logic [31:0] araddr;
   logic        arvalid;
   logic        arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        rready;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        inst_fault;
   logic        inst_valid;
   logic        inst_ready;

   int n_pass  = 0;
   int n_total = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   ysyx_25060170_ifetch_mem #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk          (clk),
      .rst          (rst),
      .pc_i         (pc_i),
      .flush_i      (flush),
      .pc_advance_o (pc_advance),
      .araddr_o     (araddr),
      .arvalid_o    (arvalid),
      .arready_i    (arready),
      .rdata_i      (rdata),
      .rresp_i      (rresp),
      .rvalid_i     (rvalid),
      .rready_o     (rready),
      .inst_o       (inst),
      .inst_pc_o    (inst_pc),
      .inst_fault_o (inst_fault),
      .inst_valid_o (inst_valid),
      .inst_ready_i (inst_ready)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic samp();
      #1;
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   // random-phase model state
   logic [31:0] pc;
   logic        hold_exp;
   logic [31:0] exp_inst;
   logic [31:0] exp_pc;
   logic        exp_fault;
   logic        busy;
   logic [31:0] m_addr;
   int          m_delay;
   logic [1:0]  m_resp;
   logic        m_drop;
   logic        txn_flushed;
   logic        prev_arv;
   logic        prev_arr;
   logic [31:0] prev_addr;
   logic        exp_adv;
   int          consumed;

   initial begin
      rst = 1'b1; pc_i = 32'h0; flush = 1'b0; arready = 1'b0; rdata = 32'h0;
      rresp = 2'b00; rvalid = 1'b0; inst_ready = 1'b0;
      #3;
      chk("rst_arvalid", {31'd0, arvalid}, 32'd0);
      chk("rst_rready", {31'd0, rready}, 32'd0);
      chk("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
      chk("rst_pc_adv", {31'd0, pc_advance}, 32'd0);
      chk("rst_araddr", araddr, 32'd0);
      chk("rst_inst", inst, 32'd0);
      chk("rst_inst_pc", inst_pc, 32'd0);
      chk("rst_fault", {31'd0, inst_fault}, 32'd0);
      cyc(); cyc();
      rst = 1'b0;

      // zero-wait fetch
      pc_i = 32'h8000_0000; arready = 1'b1; rvalid = 1'b1; rdata = 32'h0000_0413;
      inst_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         if (k > 0) cyc();
         samp();
         chk("zw_arvalid", {31'd0, arvalid}, {31'd0, k == 1});
         chk("zw_rready", {31'd0, rready}, {31'd0, k == 2});
         chk("zw_inst_valid", {31'd0, inst_valid}, {31'd0, k == 3});
         chk("zw_pc_adv", {31'd0, pc_advance}, {31'd0, k == 3});
         if (k == 1) chk("zw_araddr", araddr, 32'h8000_0000);
         if (k == 3) begin
            chk("zw_inst", inst, 32'h0000_0413);
            chk("zw_inst_pc", inst_pc, 32'h8000_0000);
            chk("zw_fault", {31'd0, inst_fault}, 32'd0);
         end
      end

      // wait states: arready after 3 cycles, rvalid after 2
      cyc();
      pc_i = 32'h8000_0004; rdata = 32'h00A0_0093;
      for (int k = 0; k < 9; k++) begin
         if (k > 0) cyc();
         arready = (k == 4);
         rvalid  = (k == 7);
         samp();
         chk("ws_arvalid", {31'd0, arvalid}, {31'd0, k >= 1 && k <= 4});
         if (k >= 1 && k <= 4) chk("ws_araddr", araddr, 32'h8000_0004);
         chk("ws_rready", {31'd0, rready}, {31'd0, k >= 5 && k <= 7});
         chk("ws_inst_valid", {31'd0, inst_valid}, {31'd0, k == 8});
         chk("ws_pc_adv", {31'd0, pc_advance}, {31'd0, k == 8});
         if (k == 8) chk("ws_inst", inst, 32'h00A0_0093);
      end

      // decode backpressure for 5 cycles
      cyc();
      pc_i = 32'h8000_0008; arready = 1'b1; rvalid = 1'b1; rdata = 32'h0010_0073;
      for (int k = 0; k < 9; k++) begin
         if (k > 0) cyc();
         inst_ready = (k == 8);
         samp();
         chk("bp_arvalid", {31'd0, arvalid}, {31'd0, k == 1});
         chk("bp_inst_valid", {31'd0, inst_valid}, {31'd0, k >= 3});
         chk("bp_pc_adv", {31'd0, pc_advance}, {31'd0, k == 8});
         if (k >= 3) begin
            chk("bp_inst", inst, 32'h0010_0073);
            chk("bp_inst_pc", inst_pc, 32'h8000_0008);
         end
      end

      // flush in REQ discards its data; then a faulting fetch at the target
      cyc();
      pc_i = 32'h8000_000C; arready = 1'b0; rvalid = 1'b0; rdata = 32'hDEAD_BEEF;
      inst_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         if (k > 0) cyc();
         flush   = (k == 1);
         arready = (k == 2 || k == 5);
         rvalid  = (k == 3 || k == 6);
         if (k >= 2) pc_i = 32'h8000_0100;
         if (k == 6) begin
            rdata = 32'h1234_5678; rresp = 2'b10;
         end
         samp();
         chk("fl_arvalid", {31'd0, arvalid}, {31'd0, k == 1 || k == 2 || k == 5});
         if (k == 1 || k == 2) chk("fl_araddr_old", araddr, 32'h8000_000C);
         if (k == 5) chk("fl_araddr_new", araddr, 32'h8000_0100);
         chk("fl_rready", {31'd0, rready}, {31'd0, k == 3 || k == 6});
         chk("fl_inst_valid", {31'd0, inst_valid}, {31'd0, k == 7});
         chk("fl_pc_adv", {31'd0, pc_advance}, {31'd0, k == 1 || k == 7});
         if (k == 7) begin
            chk("ft_inst", inst, 32'h1234_5678);
            chk("ft_inst_pc", inst_pc, 32'h8000_0100);
            chk("ft_fault", {31'd0, inst_fault}, 32'd1);
         end
      end

      // async reset while in WAIT_R
      cyc();
      flush = 1'b0; pc_i = 32'h8000_0104; rresp = 2'b00; arready = 1'b1; rvalid = 1'b0;
      samp();
      cyc(); samp();
      chk("ar_req", {31'd0, arvalid}, 32'd1);
      cyc(); samp();
      chk("ar_wait_r", {31'd0, rready}, 32'd1);
      #1 rst = 1'b1;
      #1;
      chk("ar_arvalid", {31'd0, arvalid}, 32'd0);
      chk("ar_rready", {31'd0, rready}, 32'd0);
      chk("ar_inst_valid", {31'd0, inst_valid}, 32'd0);
      chk("ar_pc_adv", {31'd0, pc_advance}, 32'd0);
      chk("ar_araddr", araddr, 32'd0);
      chk("ar_inst", inst, 32'd0);
      chk("ar_inst_pc", inst_pc, 32'd0);
      chk("ar_fault", {31'd0, inst_fault}, 32'd0);
      rvalid = 1'b1; rdata = 32'hCAFE_F00D;
      cyc();
      rst = 1'b0; pc_i = 32'h8000_0200; arready = 1'b0;
      samp();
      chk("ar_idle_arvalid", {31'd0, arvalid}, 32'd0);
      chk("ar_idle_rready", {31'd0, rready}, 32'd0);
      cyc(); samp();
      chk("ar_new_req", {31'd0, arvalid}, 32'd1);
      chk("ar_new_addr", araddr, 32'h8000_0200);
      chk("ar_no_inst", {31'd0, inst_valid}, 32'd0);

      // randomized run
      rst = 1'b1; rvalid = 1'b0; arready = 1'b0; inst_ready = 1'b0;
      cyc();
      rst = 1'b0;
      pc = 32'h8000_0000; hold_exp = 1'b0; busy = 1'b0; txn_flushed = 1'b0;
      prev_arv = 1'b0; prev_arr = 1'b0; prev_addr = 32'h0; consumed = 0;
      exp_inst = 32'h0; exp_pc = 32'h0; exp_fault = 1'b0;
      m_addr = 32'h0; m_delay = 0; m_resp = 2'b00; m_drop = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if (i > 0) cyc();
         pc_i       = pc;
         arready    = 1'($urandom_range(0, 1));
         inst_ready = ($urandom_range(0, 2) != 0);
         if (busy && m_delay == 0) begin
            rvalid = 1'b1; rdata = mem_word(m_addr); rresp = m_resp;
         end else begin
            rvalid = 1'b0; rdata = $urandom; rresp = 2'($urandom_range(0, 3));
         end
         flush = !rready && ($urandom_range(0, 11) == 0);
         samp();
         if (arvalid && !prev_arv) chk("rnd_req_addr", araddr, pc);
         if (prev_arv && !prev_arr) begin
            chk("rnd_arvalid_hold", {31'd0, arvalid}, 32'd1);
            chk("rnd_araddr_hold", araddr, prev_addr);
         end
         chk("rnd_inst_valid", {31'd0, inst_valid}, {31'd0, hold_exp});
         if (hold_exp) begin
            chk("rnd_inst", inst, exp_inst);
            chk("rnd_inst_pc", inst_pc, exp_pc);
            chk("rnd_fault", {31'd0, inst_fault}, {31'd0, exp_fault});
         end
         exp_adv = (hold_exp && inst_ready) || flush;
         chk("rnd_pc_adv", {31'd0, pc_advance}, {31'd0, exp_adv});

         if (hold_exp && (inst_ready || flush)) begin
            hold_exp = 1'b0;
            if (inst_ready) consumed++;
         end
         if (rvalid && rready) begin
            busy = 1'b0;
            if (!(m_drop || flush)) begin
               hold_exp  = 1'b1;
               exp_inst  = mem_word(m_addr);
               exp_pc    = m_addr;
               exp_fault = (m_resp != 2'b00);
            end
         end else if (busy && m_delay > 0) begin
            m_delay--;
         end
         if (arvalid && flush) txn_flushed = 1'b1;
         if (arvalid && arready) begin
            busy        = 1'b1;
            m_addr      = araddr;
            m_delay     = $urandom_range(0, 3);
            m_resp      = ($urandom_range(0, 7) == 0) ? 2'b10 : 2'b00;
            m_drop      = txn_flushed;
            txn_flushed = 1'b0;
         end
         prev_arv  = arvalid;
         prev_arr  = arready;
         prev_addr = araddr;
         if (flush) pc = {$urandom} & 32'hFFFF_FFFC;
         else if (exp_adv) pc = pc + 32'd4;
      end
      chk("rnd_progress", {31'd0, consumed > 100}, 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/ysyx_25060170_ifetch_mem.md
Name: ysyx_25060170_ifetch_mem

Overview:
- Instruction-fetch memory stage directly downstream of the PC-generating IFU.
- Takes the current PC and fetches the 32-bit instruction from instruction memory over an AXI4-Lite-style read channel (AR/R).
- Presents the instruction plus its PC to the decode stage with valid/ready.
- Drives the IFU's PC-write enable, so the PC advances only when an instruction is consumed or a jump redirect occurs.

Parameters:
- ADDR_W, 32, width of PC and read address.
- DATA_W, 32, width of the instruction word and read data.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- pc_i  in  ADDR_W  current PC from IFU pc_o.
- flush_i  in  1  jump/redirect taken this cycle; the IFU loads the jump target at this edge.
- pc_advance_o  out  1  to IFU ready_i; PC write enable.
- araddr_o  out  ADDR_W  read address.
- arvalid_o  out  1  read address valid.
- arready_i  in  1  memory accepts address.
- rdata_i  in  DATA_W  read data.
- rresp_i  in  2  read response; 2'b00 = OKAY.
- rvalid_i  in  1  read data valid.
- rready_o  out  1  ready for read data.
- inst_o  out  DATA_W  fetched instruction.
- inst_pc_o  out  ADDR_W  PC of inst_o.
- inst_fault_o  out  1  access fault for inst_o (rresp != OKAY).
- inst_valid_o  out  1  instruction valid to decode.
- inst_ready_i  in  1  decode accepts instruction.

Behaviour:
- Reset (asynchronous, active-high): state IDLE, discard=0.
  - All outputs are 0 during reset: arvalid_o, rready_o, inst_valid_o, pc_advance_o, araddr_o, inst_o, inst_pc_o, inst_fault_o.
- State IDLE:
  - if flush_i is 0: capture pc_i into araddr_o, go to REQ.
  - if flush_i is 1: stay in IDLE, because pc_i is stale.
- State REQ:
  - arvalid_o=1.
  - araddr_o and arvalid_o are held stable until arready_i; arvalid is never withdrawn, even on flush.
  - On arready_i, go to WAIT_R.
  - flush_i in REQ sets discard=1.
- State WAIT_R:
  - rready_o=1.
  - On rvalid_i:
    - if discard, or flush_i is 1 this cycle: drop the data, clear discard, go to IDLE.
    - otherwise: latch inst_o=rdata_i, inst_pc_o=araddr_o, inst_fault_o=(rresp_i!=0), and go to HOLD.
- State HOLD:
  - inst_valid_o=1; inst_o, inst_pc_o and inst_fault_o are stable until handshake.
  - On inst_valid_o & inst_ready_i: go to IDLE.
  - On flush_i without handshake: drop the instruction, go to IDLE.
  - On flush_i with handshake in the same cycle: the instruction is consumed, go to IDLE.
- pc_advance_o (combinational):
  - pc_advance_o = (state==HOLD & inst_ready_i) | flush_i.
  - Exactly one PC write per consumed instruction or redirect; never two for one event.
- Latency:
  - With arready_i and rvalid_i high immediately: IDLE(c0), REQ(c1), WAIT_R(c2), HOLD(c3). inst_valid_o rises at c3.
  - Throughput is one instruction per 4 cycles minimum.
  - Arbitrary memory wait states are tolerated in REQ and WAIT_R.
- No outstanding-transaction count above 1; no buffering beyond one instruction.
- Reset mid-transaction: the stage returns to IDLE immediately.
  - Any in-flight memory response arriving after reset is ignored; rready_o is 0 in IDLE.
  - The memory side is reset by the same rst.

Decomposition:
- Shared package/header: state encoding constants (IDLE, REQ, WAIT_R, HOLD, 2 bits) and RESP_OKAY=2'b00.
- One natural sub-module: ysyx_25060170_inst_hold_reg, the HOLD-stage register for inst/pc/fault with a load enable.
- The FSM stays in the top.

Test Plan:
- Zero-wait fetch: pc_i=0x8000_0000, arready=1, rvalid=1, rdata=0x0000_0413, decode ready=1.
  -> arvalid at c1 with araddr=0x8000_0000; inst_valid at c3 with inst_o=0x0000_0413; pc_advance pulses at c3 only.
- Wait states: arready delayed 3 cycles, rvalid delayed 2 cycles.
  -> arvalid and araddr stable throughout; inst_valid at c8; exactly one pc_advance.
- Decode backpressure: inst_ready=0 for 5 cycles in HOLD.
  -> inst_o/inst_pc_o unchanged, no new arvalid, pc_advance=0 until ready.
- Flush during REQ (arready low), then arready, then rvalid with rdata=0xDEAD_BEEF.
  -> data discarded, inst_valid never asserted for it.
  -> next request uses the new pc_i=0x8000_0100; pc_advance=1 only in the flush cycle.
- Fault: rresp=2'b10, rdata=0x1234_5678.
  -> inst_valid with inst_fault_o=1, inst_pc_o equal to the request address.
- Asynchronous reset asserted while in WAIT_R.
  -> all outputs 0 immediately (before next edge); after release, IDLE then a new REQ with the current pc_i.
